// File: rtl/core_pkg.sv
// Shared definitions for the core controller: instruction bit positions,
// the IDLE instruction word and the controller state encoding.
package core_pkg;

    localparam int INST_WIDTH = 50;

    localparam int OUT_LOAD_B  = 49;
    localparam int CEN_OMEM_B  = 48;
    localparam int WEN_OMEM_B  = 47;
    localparam int A_OMEM_LSB  = 36;
    localparam int MODE_B      = 35;
    localparam int DATA_MODE_B = 34;
    localparam int ACC_B       = 33;
    localparam int CEN_PMEM_B  = 32;
    localparam int WEN_PMEM_B  = 31;
    localparam int A_PMEM_LSB  = 20;
    localparam int CEN_XMEM_B  = 19;
    localparam int WEN_XMEM_B  = 18;
    localparam int A_XMEM_LSB  = 7;
    localparam int OFIFO_RD_B  = 6;
    localparam int IFIFO_WR_B  = 5;
    localparam int IFIFO_RD_B  = 4;
    localparam int L0_RD_B     = 3;
    localparam int L0_WR_B     = 2;
    localparam int EXECUTE_B   = 1;
    localparam int LOAD_B      = 0;

    // All SRAM enables deasserted (active-low), everything else zero.
    localparam logic [INST_WIDTH-1:0] IDLE_WORD =
        (INST_WIDTH'(1) << CEN_OMEM_B) | (INST_WIDTH'(1) << WEN_OMEM_B) |
        (INST_WIDTH'(1) << CEN_PMEM_B) | (INST_WIDTH'(1) << WEN_PMEM_B) |
        (INST_WIDTH'(1) << CEN_XMEM_B) | (INST_WIDTH'(1) << WEN_XMEM_B);

    typedef enum logic [2:0] {
        IDLE,
        WT_RD,
        WT_LD,
        ACT,
        DRAIN,
        FIN
    } state_t;

endpackage

// File: rtl/core_ctrl_if.sv
// Host-side bus of the core controller: pass request, pass geometry,
// OFIFO status, and the registered instruction/status outputs.
interface core_ctrl_if #(
    parameter int AW     = 11,
    parameter int INST_W = 50
);
    logic              start;
    logic [AW-1:0]     wt_base;
    logic [AW-1:0]     act_base;
    logic [AW-1:0]     out_base;
    logic [AW-1:0]     num_act;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;

    modport master (
        output start, wt_base, act_base, out_base, num_act, ofifo_valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, wt_base, act_base, out_base, num_act, ofifo_valid,
        output inst, busy, done
    );
endinterface

// File: rtl/core_ctrl_cnt.sv
// Loadable up-counter with a terminal-count flag raised when the count
// equals the supplied last value.
module core_ctrl_cnt
    import core_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] d,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] q,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

    assign tc = (q == last);

endmodule

// File: rtl/core_ctrl.sv
// Weight-stationary pass sequencer: weight read, weight load, activation
// stream, output drain. Define CORE_CTRL_SFP_EN to store SFP output on drain.
module core_ctrl
    import core_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int AW     = 11,
    parameter int INST_W = 50
) (
    input  logic       clk,
    input  logic       reset,
    core_ctrl_if.slave bus
);

    state_t            state, state_n;
    logic [AW-1:0]     wt_q, act_q, out_q, num_q;
    logic [INST_W-1:0] inst_q, inst_n;
    logic              busy_q, done_q;
    logic              rd_q, rd_n;

    logic              ph_clr, ph_en, ph_tc;
    logic [AW-1:0]     ph, ph_last;
    logic              dr_clr, dr_en, dr_tc;
    logic [AW-1:0]     dr, dr_last;

    core_ctrl_cnt #(.W(AW)) u_phase (
        .clk   (clk),
        .reset (reset),
        .ld    (ph_clr),
        .d     ('0),
        .en    (ph_en),
        .last  (ph_last),
        .q     (ph),
        .tc    (ph_tc)
    );

    core_ctrl_cnt #(.W(AW)) u_drain (
        .clk   (clk),
        .reset (reset),
        .ld    (dr_clr),
        .d     ('0),
        .en    (dr_en),
        .last  (dr_last),
        .q     (dr),
        .tc    (dr_tc)
    );

    assign dr_last = num_q - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Outputs are the registered decode of the current state, so every
    // output trails the state register by one cycle, uniformly.
    always_comb begin
        state_n = state;
        inst_n  = INST_W'(IDLE_WORD);
        rd_n    = 1'b0;
        ph_clr  = 1'b0;
        ph_en   = 1'b0;
        ph_last = '0;
        dr_clr  = 1'b0;
        dr_en   = 1'b0;

        inst_n[L0_WR_B] = rd_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = WT_RD;
                    ph_clr  = 1'b1;
                    dr_clr  = 1'b1;
                end
            end

            WT_RD: begin
                ph_last                     = AW'(COL - 1);
                inst_n[CEN_PMEM_B]          = 1'b0;
                inst_n[A_PMEM_LSB +: AW]    = wt_q + ph;
                inst_n[MODE_B]              = 1'b1;
                inst_n[DATA_MODE_B]         = 1'b1;
                rd_n                        = 1'b1;
                if (ph_tc) begin
                    state_n = WT_LD;
                    ph_clr  = 1'b1;
                end else begin
                    ph_en = 1'b1;
                end
            end

            WT_LD: begin
                ph_last         = AW'(ROW + COL - 1);
                inst_n[L0_RD_B] = 1'b1;
                inst_n[LOAD_B]  = 1'b1;
                inst_n[MODE_B]  = 1'b1;
                if (ph_tc) begin
                    state_n = (num_q == '0) ? FIN : ACT;
                    ph_clr  = 1'b1;
                end else begin
                    ph_en = 1'b1;
                end
            end

            // Counts 0..num_act; the final count is the trailing l0_wr-only cycle.
            ACT: begin
                ph_last = num_q;
                if (!ph_tc) begin
                    inst_n[CEN_XMEM_B]       = 1'b0;
                    inst_n[A_XMEM_LSB +: AW] = act_q + ph;
                    inst_n[MODE_B]           = 1'b1;
                    inst_n[L0_RD_B]          = 1'b1;
                    inst_n[EXECUTE_B]        = 1'b1;
                    rd_n                     = 1'b1;
                    ph_en                    = 1'b1;
                end else begin
                    state_n = DRAIN;
                    ph_clr  = 1'b1;
                end
            end

            DRAIN: begin
                if (bus.ofifo_valid) begin
                    inst_n[OFIFO_RD_B]       = 1'b1;
                    inst_n[CEN_OMEM_B]       = 1'b0;
                    inst_n[WEN_OMEM_B]       = 1'b0;
                    inst_n[A_OMEM_LSB +: AW] = out_q + dr;
`ifdef CORE_CTRL_SFP_EN
                    inst_n[OUT_LOAD_B]       = 1'b1;
`else
                    inst_n[OUT_LOAD_B]       = 1'b0;
`endif
                    if (dr_tc) begin
                        state_n = FIN;
                    end else begin
                        dr_en = 1'b1;
                    end
                end
            end

            FIN: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        inst_n[ACC_B]      = 1'b0;
        inst_n[IFIFO_WR_B] = 1'b0;
        inst_n[IFIFO_RD_B] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q <= INST_W'(IDLE_WORD);
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            wt_q   <= '0;
            act_q  <= '0;
            out_q  <= '0;
            num_q  <= '0;
        end else begin
            inst_q <= inst_n;
            busy_q <= (state != IDLE) && (state != FIN);
            done_q <= (state == FIN);
            rd_q   <= rd_n;
            if (state == IDLE && bus.start) begin
                wt_q  <= bus.wt_base;
                act_q <= bus.act_base;
                out_q <= bus.out_base;
                num_q <= bus.num_act;
            end
        end
    end

    assign bus.inst = inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter ROW, default 8, number of PE rows; sets the weight-load length.
REQ-002 Parameter COL, default 8, number of PE columns; sets the weight-load length.
REQ-003 Parameter AW, default 11, SRAM address width; all SRAMs are 2048 deep.
REQ-004 Parameter INST_W, default 50, instruction word width.
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to run one weight-stationary pass.
REQ-008 wt_base  input  AW  first weight vector address in the weight SRAM.
REQ-009 act_base  input  AW  first activation vector address in the activation SRAM.
REQ-010 out_base  input  AW  first result address in the output SRAM.
REQ-011 num_act  input  AW  number of activation vectors; equals the number of results.
REQ-012 ofifo_valid  input  1  OFIFO is non-empty; it is first-word-fall-through.
REQ-013 inst  output  INST_W  instruction word driving the core.
REQ-014 busy  output  1  high from the cycle after start is accepted until done.
REQ-015 done  output  1  one-cycle pulse at the end of the pass.

Function
REQ-016 The inst fields SHALL be:
- [49] output_loading_mode; [48] CEN_omem; [47] WEN_omem; [46:36] A_omem.
- [35] mode; [34] data_mode; [33] acc.
- [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem.
- [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem.
- [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
REQ-017 CEN and WEN SHALL be active-low.
REQ-018 The IDLE word SHALL have all CEN/WEN bits at 1 and every other bit at 0.
REQ-019 inst, busy and done SHALL be registered outputs, with no combinational path from any input.
REQ-020 The FSM states SHALL be IDLE, WT_RD, WT_LD, ACT, DRAIN, FIN.
REQ-021 IDLE: start=1 SHALL latch all base/count inputs, go to WT_RD and set busy.
REQ-022 start SHALL be ignored whenever busy=1.
REQ-023 WT_RD SHALL last COL cycles. Cycle k: CEN_pmem=0, WEN_pmem=1, A_pmem=wt_base+k, mode=1, data_mode=1.
REQ-024 l0_wr SHALL be asserted exactly one cycle after each SRAM read, matching the one-cycle SRAM read latency. The same delay rule applies in ACT.
REQ-025 WT_LD SHALL last ROW+COL cycles with l0_rd=1, load=1, mode=1; then go to ACT.
REQ-026 ACT SHALL last num_act cycles. Cycle j: CEN_xmem=0, WEN_xmem=1, A_xmem=act_base+j, mode=1, data_mode=0, l0_rd=1, execute=1.
REQ-027 ACT SHALL add one trailing cycle carrying only the delayed l0_wr; then go to DRAIN.
REQ-028 DRAIN: each cycle with ofifo_valid=1 SHALL assert ofifo_rd=1, CEN_omem=0, WEN_omem=0, A_omem=out_base+n, then increment n.
REQ-029 DRAIN: each cycle with ofifo_valid=0 SHALL emit the IDLE word and hold n.
REQ-030 DRAIN SHALL exit to FIN after num_act writes.
REQ-031 FIN SHALL last one cycle: done=1, busy=0, IDLE word; then go to IDLE.
REQ-032 Address arithmetic SHALL be modulo 2^AW (base+offset wraps past 2047 to 0).
REQ-033 num_act=0 SHALL skip ACT and DRAIN and go from WT_LD straight to FIN.
REQ-034 acc SHALL be 0 in every state.
REQ-035 ififo_wr and ififo_rd SHALL be 0 in every state.

Reset
REQ-036 reset SHALL force IDLE, inst=IDLE word, busy=0, done=0 and clear all counters at the next edge, including mid-pass.
REQ-037 start sampled in the same cycle as reset SHALL be ignored.

Configuration
REQ-038 With macro CORE_CTRL_SFP_EN defined, inst[49]=1 SHALL be asserted on every DRAIN write cycle, so the output SRAM stores SFP output.
REQ-039 Without CORE_CTRL_SFP_EN, inst[49] SHALL be constant 0.

Structure
REQ-040 A shared package core_pkg SHALL hold:
- the inst bit-position constants;
- the IDLE word constant;
- the state enum typedef.
REQ-041 One sub-module, core_ctrl_cnt (loadable up-counter with terminal-count flag), SHALL be instantiated for the phase counter and the drain counter.

Verification
REQ-042 Bench scenarios:
- start, wt_base=0x10, num_act=4, ofifo_valid=1 -> A_pmem 0x10..0x17; 16 load cycles; A_xmem act_base..+3; 4 omem writes at out_base..+3; done pulses once.
- ofifo_valid toggled 1,0,0,1,1,0,1 during DRAIN -> omem writes only in valid cycles; A_omem is contiguous.
- act_base=2046, num_act=4 -> A_xmem 2046, 2047, 0, 1.
- num_act=0 -> no xmem reads, no omem writes; done follows WT_LD.
- reset asserted in ACT cycle 2 -> next cycle inst=IDLE word, busy=0; a new start runs a full pass.
- start pulsed while busy -> no change in sequence; with CORE_CTRL_SFP_EN, inst[49]=1 exactly on DRAIN write cycles.
